// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core: opcodes and
// the control encodings used between the decoder, ALU and writeback mux.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_IMM,
        WB_PC_IMM
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_BRANCH,
        PC_JAL,
        PC_JALR
    } pc_sel_e;

endpackage

// File: rtl/riscv_processor_alu.sv
// Combinational 32-bit ALU: add/sub wrap around, slt is a signed compare.
module alu
    import riscv_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = a + b;
        case (alu_ctrl_e'(ctrl))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I-subset core: PC, register file, decoder and immediate
// generation live here; instruction and data memories are external.
module riscv_processor
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        write_enable,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val;

    logic [31:0] imm;
    logic        reg_we;
    logic        mem_we;
    logic        alu_src_imm;
    alu_ctrl_e   alu_ctrl;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;

    logic [31:0] alu_b, alu_res;
    logic [31:0] pc_plus4, pc_imm, wb_data;
    logic        br_eq, br_lt;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};

    // x0 is never written, so its flop stays at its reset value of zero
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign br_eq = (rs1_val == rs2_val);
    assign br_lt = ($signed(rs1_val) < $signed(rs2_val));

    always_comb begin
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        alu_src_imm = 1'b0;
        alu_ctrl    = ALU_ADD;
        imm         = imm_i;
        wb_sel      = WB_ALU;
        pc_sel      = PC_PLUS4;
        case (opcode)
            OP: begin
                reg_we = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: alu_ctrl = ALU_ADD;
                    10'b0100000_000: alu_ctrl = ALU_SUB;
                    10'b0000000_111: alu_ctrl = ALU_AND;
                    10'b0000000_110: alu_ctrl = ALU_OR;
                    10'b0000000_010: alu_ctrl = ALU_SLT;
                    default:         reg_we   = 1'b0;
                endcase
            end
            OP_IMM: begin
                reg_we      = (funct3 == 3'b000);
                alu_src_imm = 1'b1;
            end
            LOAD: begin
                reg_we      = (funct3 == 3'b010);
                alu_src_imm = 1'b1;
                wb_sel      = WB_MEM;
            end
            STORE: begin
                mem_we      = (funct3 == 3'b010);
                alu_src_imm = 1'b1;
                imm         = imm_s;
            end
            BRANCH: begin
                imm = imm_b;
                if ((funct3 == 3'b000 && br_eq) || (funct3 == 3'b100 && br_lt))
                    pc_sel = PC_BRANCH;
            end
            JAL: begin
                reg_we = 1'b1;
                imm    = imm_j;
                wb_sel = WB_PC4;
                pc_sel = PC_JAL;
            end
            JALR: begin
                if (funct3 == 3'b000) begin
                    reg_we      = 1'b1;
                    alu_src_imm = 1'b1;
                    wb_sel      = WB_PC4;
                    pc_sel      = PC_JALR;
                end
            end
            LUI: begin
                reg_we = 1'b1;
                imm    = imm_u;
                wb_sel = WB_IMM;
            end
            AUIPC: begin
                reg_we = 1'b1;
                imm    = imm_u;
                wb_sel = WB_PC_IMM;
            end
            default: ;
        endcase
    end

    assign alu_b = alu_src_imm ? imm : rs2_val;

    alu u_alu (
        .ctrl   (alu_ctrl),
        .a      (rs1_val),
        .b      (alu_b),
        .result (alu_res)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_imm   = pc_q + imm;

    always_comb begin
        case (wb_sel)
            WB_ALU:    wb_data = alu_res;
            WB_MEM:    wb_data = data_from_mem;
            WB_PC4:    wb_data = pc_plus4;
            WB_IMM:    wb_data = imm;
            WB_PC_IMM: wb_data = pc_imm;
            default:   wb_data = alu_res;
        endcase
    end

    always_comb begin
        case (pc_sel)
            PC_PLUS4:  pc_d = pc_plus4;
            PC_BRANCH: pc_d = pc_imm;
            PC_JAL:    pc_d = pc_imm;
            PC_JALR:   pc_d = alu_res & ~32'd1;
            default:   pc_d = pc_plus4;
        endcase
    end

    // jalr target comes from the old rs1 because the write lands at the edge
    always_comb begin
        regs_d = regs_q;
        if (reg_we && rd != 5'd0)
            regs_d[rd] = wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
        end
    end

    assign pc             = pc_q;
    assign write_enable   = mem_we & reset;
    assign address_to_mem = alu_res;
    assign data_to_mem    = rs2_val;

endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for the single-cycle core with behavioural instruction and
// data memories; expectations go through a scoreboard queue.
module tb_riscv_processor;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        write_enable;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    int n_assert = 0;
    int n_fail   = 0;

    riscv_processor dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instruction    (instruction),
        .write_enable   (write_enable),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction   = imem[pc[7:2]];
    assign data_from_mem = dmem[address_to_mem[7:2]];

    always @(posedge clk)
        if (write_enable)
            dmem[address_to_mem[7:2]] <= data_to_mem;

    typedef enum int {K_PC, K_WE, K_ADDR, K_DATA, K_REG, K_DMEM} kind_e;
    typedef struct packed {
        kind_e       kind;
        logic [5:0]  idx;
        logic [31:0] val;
    } exp_t;

    exp_t  sb_q  [$];
    string tag_q [$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], STORE};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] observe(kind_e k, logic [5:0] idx);
        case (k)
            K_PC:    return pc;
            K_WE:    return {31'b0, write_enable};
            K_ADDR:  return address_to_mem;
            K_DATA:  return data_to_mem;
            K_REG:   return dut.regs_q[idx[4:0]];
            K_DMEM:  return dmem[idx];
            default: return 32'hx;
        endcase
    endfunction

    task automatic push(string tag, kind_e k, int idx, logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.idx  = idx[5:0];
        e.val  = v;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_sb();
        exp_t        e;
        string       tag;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            tag = tag_q.pop_front();
            obs = observe(e.kind, e.idx);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e.val);
            end
        end
    endtask

    task automatic load_nops();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    // short asynchronous reset pulse between edges, ending before the next posedge
    task automatic restart();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        load_nops();
        imem[0] = enc_s(12'd4, 5'd2, 5'd1);
        step(2);

        // held in reset with a store at pc 0
        push("rst_pc",   K_PC,   0, 32'h0);
        push("rst_we",   K_WE,   0, 32'h0);
        push("rst_addr", K_ADDR, 0, 32'h4);
        push("rst_data", K_DATA, 0, 32'h0);
        check_sb();

        load_nops();
        reset = 1'b1;
        push("nop_pc0", K_PC, 0, 32'h0); check_sb();
        step(1); push("nop_pc4", K_PC, 0, 32'h4); check_sb();
        step(1); push("nop_pc8", K_PC, 0, 32'h8); check_sb();

        // arithmetic
        load_nops();
        imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
        imem[1] = enc_i(-12'sd3, 5'd0, 3'b000, 5'd2, OP_IMM);
        imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        imem[3] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
        imem[4] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5);
        imem[5] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_IMM);
        imem[6] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6);
        imem[7] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd7);
        imem[8] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd8);
        restart();
        step(9);
        push("ar_x1",  K_REG, 1, 32'd5);
        push("ar_x2",  K_REG, 2, 32'hFFFF_FFFD);
        push("ar_add", K_REG, 3, 32'd2);
        push("ar_sub", K_REG, 4, 32'hFFFF_FFF8);
        push("ar_slt", K_REG, 5, 32'd1);
        push("ar_x0",  K_REG, 0, 32'd0);
        push("ar_slt0", K_REG, 6, 32'd0);
        push("ar_and", K_REG, 7, 32'd5);
        push("ar_or",  K_REG, 8, 32'hFFFF_FFFD);
        push("ar_pc",  K_PC,  0, 32'h24);
        check_sb();

        // memory
        load_nops();
        imem[0] = enc_i(12'h040, 5'd0, 3'b000, 5'd1, OP_IMM);
        imem[1] = enc_i(12'h123, 5'd0, 3'b000, 5'd2, OP_IMM);
        imem[2] = enc_s(12'd4, 5'd2, 5'd1);
        imem[3] = enc_i(12'd4, 5'd1, 3'b010, 5'd3, LOAD);
        imem[4] = enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4);
        restart();
        step(2);
        push("sw_we",   K_WE,   0, 32'd1);
        push("sw_addr", K_ADDR, 0, 32'h44);
        push("sw_data", K_DATA, 0, 32'h123);
        check_sb();
        step(1);
        push("lw_we",   K_WE,   0,  32'd0);
        push("lw_addr", K_ADDR, 0,  32'h44);
        push("sw_mem",  K_DMEM, 17, 32'h123);
        check_sb();
        step(1); push("lw_x3", K_REG, 3, 32'h123); check_sb();
        step(1); push("lw_dep", K_REG, 4, 32'h246); check_sb();

        // branches
        load_nops();
        imem[0]  = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM);
        imem[1]  = enc_i(12'd1, 5'd0, 3'b000, 5'd2, OP_IMM);
        imem[4]  = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
        imem[6]  = enc_b(13'd8, 5'd1, 5'd2, 3'b100);
        imem[7]  = enc_i(-12'sd1, 5'd0, 3'b000, 5'd3, OP_IMM);
        imem[8]  = enc_b(13'd8, 5'd1, 5'd3, 3'b100);
        imem[10] = enc_b(13'd8, 5'd3, 5'd1, 3'b000);
        imem[11] = enc_b(-13'sd8, 5'd2, 5'd3, 3'b100);
        restart();
        step(4); push("br_at10",  K_PC, 0, 32'h10); check_sb();
        step(1); push("beq_tk",   K_PC, 0, 32'h18); check_sb();
        step(1); push("blt_nt",   K_PC, 0, 32'h1C); check_sb();
        step(1); push("br_at20",  K_PC, 0, 32'h20); check_sb();
        step(1); push("blt_sgn",  K_PC, 0, 32'h28); check_sb();
        step(1); push("beq_nt",   K_PC, 0, 32'h2C); check_sb();
        step(1); push("blt_back", K_PC, 0, 32'h24); check_sb();

        // jumps
        load_nops();
        imem[8]  = enc_j(21'd12, 5'd1);
        imem[11] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR);
        imem[9]  = enc_i(12'h025, 5'd0, 3'b000, 5'd2, OP_IMM);
        imem[10] = enc_i(12'd0, 5'd2, 3'b000, 5'd2, JALR);
        restart();
        step(8); push("j_at20", K_PC, 0, 32'h20); check_sb();
        step(1);
        push("jal_pc", K_PC,  0, 32'h2C);
        push("jal_rd", K_REG, 1, 32'h24);
        check_sb();
        step(1);
        push("jalr_pc", K_PC,  0, 32'h24);
        push("jalr_x0", K_REG, 0, 32'h0);
        check_sb();
        step(1); push("j_x2", K_REG, 2, 32'h25); check_sb();
        step(1);
        push("jalr_odd", K_PC,  0, 32'h24);
        push("jalr_rd",  K_REG, 2, 32'h2C);
        check_sb();

        // U-type, undefined opcode, mid-program reset
        load_nops();
        imem[0]  = enc_u(20'h12345, 5'd5, LUI);
        imem[12] = enc_u(20'h00001, 5'd6, AUIPC);
        imem[13] = 32'hFFFF_FFFF;
        imem[14] = enc_i(12'd9, 5'd0, 3'b000, 5'd7, OP_IMM);
        restart();
        step(1); push("lui", K_REG, 5, 32'h1234_5000); check_sb();
        step(11); push("u_at30", K_PC, 0, 32'h30); check_sb();
        step(1);
        push("auipc",  K_REG, 6, 32'h1030);
        push("ud_we",  K_WE,  0, 32'd0);
        check_sb();
        step(1);
        push("ud_pc", K_PC,  0, 32'h38);
        push("ud_x5", K_REG, 5, 32'h1234_5000);
        push("ud_x6", K_REG, 6, 32'h1030);
        check_sb();
        reset = 1'b0;
        #1;
        push("mid_pc", K_PC,  0, 32'h0);
        push("mid_x5", K_REG, 5, 32'h0);
        check_sb();
        step(1);
        push("mid_x7",  K_REG, 7, 32'h0);
        push("mid_pc2", K_PC,  0, 32'h0);
        check_sb();
        reset = 1'b1;
        step(1); push("mid_rel", K_PC, 0, 32'h4); check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
